// File: rtl/ram_2d_rd_seq.sv
// ram_2d_rd_seq
//   Burst read sequencer in front of the banked RAM array (ram_2d). It accepts
//   one command (base, len, stride, skew) and issues one row read per cycle,
//   while output credits allow. Each returned NUM_RAMS*W row is captured in a
//   small first-word-fall-through FIFO and streamed out on valid/ready.
//   Reads are only issued when the in-flight reads plus the FIFO occupancy
//   leave room for the returning data, so RAM output is never dropped under
//   backpressure.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      burst command handshake (ready only in IDLE)
//   cmd_base/len/stride/skew burst descriptor (addresses taken mod D)
//   ram_re, ram_read_addr    RAM read enable and packed per-bank addresses
//   ram_dout_vld, ram_dout   RAM read return
//   out_valid/out_ready      output row stream, out_data in bank order
//   out_last                 final row of the burst
//   busy, done               not-IDLE flag, one-cycle end-of-burst pulse
module ram_2d_rd_seq #(
  parameter int NUM_RAMS   = 8,
  parameter int W          = 128,
  parameter int D          = 128,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_base,
  input  logic [15:0]              cmd_len,
  input  logic [15:0]              cmd_stride,
  input  logic                     cmd_skew,
  output logic                     ram_re,
  output logic [NUM_RAMS*32-1:0]   ram_read_addr,
  input  logic                     ram_dout_vld,
  input  logic [NUM_RAMS*W-1:0]    ram_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_RAMS*W-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           row, stride_q;
  logic                    skew_q;
  logic [15:0]             len_q;
  logic [16:0]             issued, popped, popped_nxt, len_x;
  logic [CW-1:0]           inflight, count;
  logic [CW:0]             credit_sum;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [NUM_RAMS*32-1:0]  addr_now, addr_q;
  logic [NUM_RAMS*W-1:0]   mem [FIFO_DEPTH];
  logic                    accept, issue, push, pop;
  logic                    unused_ok;

  // Bank address: D is a power of two, so AW-bit addition wraps mod D.
  function automatic logic [31:0] bank_addr(input logic [AW-1:0] r, input int bank,
                                            input logic skew);
    logic [AW-1:0] a;
    a = skew ? r + AW'(bank) : r;
    return 32'(a);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign unused_ok  = ^{cmd_base[31:AW], cmd_stride[15:AW], RD_LAT[0]};

  assign len_x      = {1'b0, len_q};
  assign accept     = (state == S_IDLE) && cmd_valid;
  assign push       = ram_dout_vld && ((state == S_RUN) || (state == S_DRAIN));
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign popped_nxt = popped + 17'(pop);
  // Credits use registered counts only: a pop this cycle frees its slot next cycle.
  assign credit_sum = {1'b0, inflight} + {1'b0, count};

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);
  assign ram_re     = issue;
  assign out_data   = mem[rd_ptr];
  assign out_last   = out_valid && ((popped + 17'd1) == len_x);
  // Address is live on an issue cycle and held afterwards.
  assign ram_read_addr = issue ? addr_now : addr_q;

  always_comb begin
    addr_now = '0;
    for (int i = 0; i < NUM_RAMS; i++) begin
      addr_now[32*i +: 32] = bank_addr(row, i, skew_q);
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = (cmd_len == 16'd0) ? S_FIN : S_RUN;
      S_RUN: begin
        if (issued == len_x)          state_nxt = S_DRAIN;
        else if (credit_sum < DEPTH_C) issue    = 1'b1;
      end
      // Leave as soon as the final row is being accepted so done follows out_last.
      S_DRAIN: if (popped_nxt == len_x) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      row      <= '0;
      stride_q <= '0;
      skew_q   <= 1'b0;
      len_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        row      <= cmd_base[AW-1:0];
        stride_q <= cmd_stride[AW-1:0];
        skew_q   <= cmd_skew;
        len_q    <= cmd_len;
        issued   <= '0;
        popped   <= '0;
      end else begin
        if (issue) begin
          row    <= row + stride_q;
          issued <= issued + 17'd1;
          addr_q <= addr_now;
        end
        if (pop) popped <= popped + 17'd1;
      end
      if (issue && !push)      inflight <= inflight + CW'(1);
      else if (push && !issue) inflight <= inflight - CW'(1);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FIFO storage: data only, qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_ram_2d_rd_seq.sv
// Bench for ram_2d_rd_seq: directed bursts plus randomized bursts, with a
// behavioural RAM and a scoreboard built from burst descriptors.
module tb_ram_2d_rd_seq;
  localparam int NR = 8;
  localparam int WW = 128;
  localparam int DD = 128;
  localparam int FD = 4;

  logic clk, rst, cmd_valid, cmd_ready, cmd_skew, ram_re, ram_dout_vld;
  logic out_valid, out_ready, out_last, busy, done;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len, cmd_stride;
  logic [NR*32-1:0] ram_read_addr;
  logic [NR*WW-1:0] ram_dout, out_data;

  typedef struct packed { logic last; logic [NR*WW-1:0] data; } row_t;

  logic [NR*32-1:0] exp_addr_q[$];
  row_t             exp_row_q[$];
  logic [NR*32-1:0] re_addr_log [4];
  logic [NR*32-1:0] mon_ea;
  row_t             mon_er;
  logic             hold_pend = 1'b0;
  logic [NR*WW-1:0] hold_data;
  logic [31:0]      salt = 32'h1234_5678;

  int n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
  int re_cnt = 0, out_cnt = 0, done_cnt = 0, hs_cyc = -1, done_cyc = -1;
  int first_re_cyc = -1, last_re_cyc = -1, first_vld_cyc = -1;
  int first_pop_cyc = -1, last_pop_cyc = -1;

  ram_2d_rd_seq #(.NUM_RAMS(NR), .W(WW), .D(DD), .RD_LAT(1), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .cmd_stride(cmd_stride), .cmd_skew(cmd_skew),
    .ram_re(ram_re), .ram_read_addr(ram_read_addr),
    .ram_dout_vld(ram_dout_vld), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] ram_word(input int bank, input logic [31:0] addr);
    return {salt, 32'(bank), addr, (addr * 32'h9E37_79B1) ^ salt};
  endfunction

  // Behavioural RAM with a one-cycle read latency.
  always @(posedge clk) begin
    ram_dout_vld <= ram_re;
    if (ram_re) begin
      for (int b = 0; b < NR; b++)
        ram_dout[WW*b +: WW] <= ram_word(b, ram_read_addr[32*b +: 32]);
    end
  end

  // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) hs_cyc = cyc;
      if (ram_re) begin
        if (re_cnt == 0) first_re_cyc = cyc;
        last_re_cyc = cyc;
        if (re_cnt < 4) re_addr_log[re_cnt] = ram_read_addr;
        re_cnt++;
        if (exp_addr_q.size() == 0) chk("re_unexpected", 1, 0);
        else begin
          mon_ea = exp_addr_q.pop_front();
          chk("ram_addr", ram_read_addr, mon_ea);
        end
      end
      chk("credit", 256'((re_cnt - out_cnt) <= FD), 1);
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", 256'(out_data == hold_data), 1);
      end
      if (!out_valid) chk("last_idle", out_last, 0);
      if (out_valid && out_ready) begin
        if (out_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        out_cnt++;
        if (exp_row_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          mon_er = exp_row_q.pop_front();
          for (int b = 0; b < NR; b++)
            chk("out_data", out_data[WW*b +: WW], mon_er.data[WW*b +: WW]);
          chk("out_last", out_last, mon_er.last);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic start_burst(input logic [31:0] base, input int len,
                             input logic [15:0] stride, input logic skew);
    int t;
    exp_addr_q.delete();
    exp_row_q.delete();
    re_cnt = 0; out_cnt = 0; done_cnt = 0; hs_cyc = -1; done_cyc = -1;
    first_re_cyc = -1; last_re_cyc = -1; first_vld_cyc = -1;
    first_pop_cyc = -1; last_pop_cyc = -1;
    salt = $urandom;
    for (int k = 0; k < len; k++) begin
      int r;
      logic [NR*32-1:0] av;
      row_t er;
      r = (int'(base % DD) + k * int'(stride % DD)) % DD;
      for (int i = 0; i < NR; i++) begin
        int a;
        a = skew ? (r + i) % DD : r;
        av[32*i +: 32] = a;
        er.data[WW*i +: WW] = ram_word(i, a);
      end
      er.last = (k == len - 1);
      exp_addr_q.push_back(av);
      exp_row_q.push_back(er);
    end
    @(posedge clk);
    #1;
    cmd_base = base; cmd_len = 16'(len); cmd_stride = stride; cmd_skew = skew;
    cmd_valid = 1'b1;
    t = 0;
    while (hs_cyc < 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1;
    cmd_valid = 1'b0;
    chk("cmd_handshake", 256'(hs_cyc >= 0), 1);
  endtask

  task automatic finish_burst(input int len);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 4 * len + 100) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", 256'(done_cnt != 0), 1);
    chk("re_count", re_cnt, len);
    chk("out_count", out_cnt, len);
    chk("addr_left", exp_addr_q.size(), 0);
    chk("rows_left", exp_row_q.size(), 0);
    if (len == 0) begin
      chk("done_lat_len0", done_cyc - hs_cyc, 1);
      chk("no_valid_len0", first_vld_cyc, -1);
    end else begin
      chk("done_after_last", done_cyc - last_pop_cyc, 1);
      chk("first_re_lat", first_re_cyc - hs_cyc, 1);
      chk("first_vld_lat", first_vld_cyc - first_re_cyc, 2);
    end
    @(posedge clk);
    #1;
    chk("done_pulse_width", done_cnt, 1);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    exp_addr_q.delete();
    exp_row_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_re"}, ram_re, 0);
    chk({tag, "_ram_addr"}, ram_read_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    logic [NR*32-1:0] v;
    int t, len;
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
    cmd_stride = '0; cmd_skew = 1'b0; out_ready = 1'b1; ram_dout_vld = 1'b0;
    ram_dout = '0;
    #23;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Linear burst, always ready.
    rdy_mode = 0;
    start_burst(32'd0, 4, 16'd1, 1'b0);
    finish_burst(4);
    chk("t1_re_span", last_re_cyc - first_re_cyc, 3);
    chk("t1_pop_span", last_pop_cyc - first_pop_cyc, 3);

    // Skewed addressing wrapping at D.
    start_burst(32'd126, 2, 16'd1, 1'b1);
    finish_burst(2);
    v = re_addr_log[0];
    chk("skew_i0_b0", v[31:0], 126);
    chk("skew_i0_b1", v[63:32], 127);
    chk("skew_i0_b2", v[95:64], 0);
    chk("skew_i0_b7", v[255:224], 5);
    v = re_addr_log[1];
    chk("skew_i1_b0", v[31:0], 127);
    chk("skew_i1_b1", v[63:32], 0);
    chk("skew_i1_b7", v[255:224], 6);

    // Backpressure: only FIFO_DEPTH reads may be outstanding.
    rdy_mode = 2;
    start_burst(32'd7, 10, 16'd3, 1'b0);
    repeat (20) @(posedge clk);
    chk("stall_re_count", re_cnt, FD);
    chk("stall_out_count", out_cnt, 0);
    rdy_mode = 0;
    finish_burst(10);

    // Zero-length burst.
    start_burst(32'd99, 0, 16'd5, 1'b0);
    finish_burst(0);

    // Large stride wrap.
    start_burst(32'd50, 3, 16'd100, 1'b0);
    finish_burst(3);
    v = re_addr_log[0]; chk("stride_row0", v[31:0], 50);
    v = re_addr_log[1]; chk("stride_row1", v[31:0], 22);
    v = re_addr_log[2]; chk("stride_row2", v[31:0], 122);
    chk("stride_row2_b7", v[255:224], 122);

    // Reset mid-burst after 3 rows, then a clean burst.
    start_burst(32'd0, 8, 16'd1, 1'b0);
    t = 0;
    while (out_cnt < 3 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("abort_reached_3", 256'(out_cnt >= 3), 1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr_q.delete();
    exp_row_q.delete();
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_cnt, 0);
    start_burst(32'd0, 4, 16'd1, 1'b0);
    finish_burst(4);
    chk("post_rst_re_span", last_re_cyc - first_re_cyc, 3);

    // Randomized bursts with random backpressure and ignored mid-burst commands.
    for (int n = 0; n < 12; n++) begin
      len = (n == 11) ? 300 : int'($urandom_range(0, 24));
      rdy_mode = int'($urandom_range(0, 1));
      start_burst($urandom, len, 16'($urandom), 1'($urandom_range(0, 1)));
      if (len >= 2) begin
        cmd_base = $urandom; cmd_len = 16'($urandom_range(1, 9));
        cmd_stride = 16'($urandom); cmd_skew = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
      finish_burst(len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
